// File: rtl/pll_sup_pkg.sv
// ----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   - default timing/retry constants used as parameter defaults
//   - supervisor state enumeration
//   - max3() helper used to size the shared down-counter timer
// ----------------------------------------------------------------------------
package pll_sup_pkg;

    localparam int DEF_RST_PULSE_CYC    = 20;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;   // 1 ms at 50 MHz
    localparam int DEF_STABLE_CYC       = 1000;
    localparam int DEF_MAX_RETRY        = 7;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset, both flops load RST_VAL
//   d_i    - asynchronous input
//   q_o    - synchronised output (2-cycle latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences a PLL out of reset, waits for a stable lock and only then
// releases downstream logic. Lock timeouts are retried until MAX_RETRY
// consecutive failures, after which the block parks in FAULT until rst.
// Ports:
//   sys_clk       - board clock, all logic on the rising edge
//   rst           - synchronous active-high reset
//   pll_locked    - raw PLL lock indicator (asynchronous)
//   force_restart - single-cycle software restart request
//   pll_rst       - active-high reset to the PLL
//   sys_rst_n     - active-low reset to downstream logic
//   ready         - high only while running
//   fault         - high only in FAULT
//   retry_cnt     - lock timeouts since the last entry into RUN
// ----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int STABLE_CYC       = DEF_STABLE_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic                           sys_clk,
    input  logic                           rst,
    input  logic                           pll_locked,
    input  logic                           force_restart,
    output logic                           pll_rst,
    output logic                           sys_rst_n,
    output logic                           ready,
    output logic                           fault,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int TMR_W   = $clog2(max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC) + 1);

    localparam logic [TMR_W-1:0]   RST_LD    = TMR_W'(RST_PULSE_CYC);
    localparam logic [TMR_W-1:0]   LOCK_LD   = TMR_W'(LOCK_TIMEOUT_CYC);
    localparam logic [TMR_W-1:0]   STAB_LD   = TMR_W'(STABLE_CYC);
    localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic locked_s;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk_i (sys_clk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    pll_state_e         state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] retry_inc;
    logic               timer_last;

    logic pll_rst_q, sys_rst_n_q, ready_q, fault_q;

    // The timer is loaded with N on state entry and the exit is taken on the
    // edge where it reads 1, so a state loaded with N lasts exactly N cycles.
    assign timer_last = (timer_q <= TMR_ONE);

    // Saturating increment: the count never wraps even if MAX_RETRY is hit.
    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;

        case (state_q)
            ST_PLL_RST: begin
                if (force_restart) begin
                    timer_d = RST_LD;
                end else if (timer_last) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = LOCK_LD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                if (force_restart) begin
                    state_d = ST_PLL_RST;
                    timer_d = RST_LD;
                end else if (locked_s) begin
                    // Lock takes priority over a coincident timeout.
                    state_d = ST_STABLE;
                    timer_d = STAB_LD;
                end else if (timer_last) begin
                    retry_d = retry_inc;
                    timer_d = RST_LD;
                    state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_PLL_RST;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_STABLE: begin
                if (force_restart) begin
                    state_d = ST_PLL_RST;
                    timer_d = RST_LD;
                end else if (!locked_s) begin
                    // A lock glitch is not a timeout: retry budget untouched.
                    state_d = ST_WAIT_LOCK;
                    timer_d = LOCK_LD;
                end else if (timer_last) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_RUN: begin
                // Restart request and lock loss collapse into one PLL_RST entry.
                if (force_restart || !locked_s) begin
                    state_d = ST_PLL_RST;
                    timer_d = RST_LD;
                end
            end

            ST_FAULT: begin
                // Parked until rst; force_restart deliberately ignored.
            end

            default: begin
                state_d = ST_PLL_RST;
                timer_d = RST_LD;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register, with no combinational input-to-output path.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_PLL_RST;
            timer_q     <= RST_LD;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
            sys_rst_n_q <= (state_d == ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Scoreboard bench: the stimulus process steps a behavioural model once per
// clock and queues every expected change of the output vector together with
// the cycle on which it must appear. A separate monitor watches the DUT
// outputs and pops/compares whenever they change.
// Output vector = {pll_rst, sys_rst_n, ready, fault, retry_cnt[1:0]}.
// ----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int TO = 32;
    localparam int SC = 8;
    localparam int MR = 2;

    localparam int P_PRST  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_RUN   = 3;
    localparam int P_FAULT = 4;

    logic       sys_clk;
    logic       rst;
    logic       pll_locked;
    logic       force_restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (RP),
        .LOCK_TIMEOUT_CYC (TO),
        .STABLE_CYC       (SC),
        .MAX_RETRY        (MR)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .force_restart (force_restart),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int         stamp;
        logic [5:0] vec;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    wire [5:0] dut_vec = {pll_rst, sys_rst_n, ready, fault, retry_cnt};

    // ---------------- behavioural model ----------------
    // Phase plus cycles spent in it; lock seen by the decision logic is the
    // raw input from two clock edges earlier (zeroed by reset).
    int         m_ph    = P_PRST;
    int         m_el    = 0;
    int         m_retry = 0;
    logic       h_old   = 1'b0;
    logic       h_new   = 1'b0;
    logic [5:0] m_prev  = 6'bxxxxxx;

    task automatic model_step(input int stamp, input logic r, input logic lk, input logic fr);
        logic       ls;
        logic [5:0] v;
        ev_t        e;
        ls = h_old;
        if (r) begin
            m_ph = P_PRST; m_el = 0; m_retry = 0;
            h_old = 1'b0; h_new = 1'b0;
        end else begin
            h_old = h_new;
            h_new = lk;
            case (m_ph)
                P_PRST: begin
                    if (fr) m_el = 0;
                    else begin
                        m_el++;
                        if (m_el == RP) begin m_ph = P_WAIT; m_el = 0; end
                    end
                end
                P_WAIT: begin
                    if (fr) begin m_ph = P_PRST; m_el = 0; end
                    else if (ls) begin m_ph = P_STAB; m_el = 0; end
                    else begin
                        m_el++;
                        if (m_el == TO) begin
                            if (m_retry < MR) m_retry++;
                            m_el = 0;
                            m_ph = (m_retry == MR) ? P_FAULT : P_PRST;
                        end
                    end
                end
                P_STAB: begin
                    if (fr) begin m_ph = P_PRST; m_el = 0; end
                    else if (!ls) begin m_ph = P_WAIT; m_el = 0; end
                    else begin
                        m_el++;
                        if (m_el == SC) begin m_ph = P_RUN; m_retry = 0; end
                    end
                end
                P_RUN: begin
                    if (fr || !ls) begin m_ph = P_PRST; m_el = 0; end
                end
                default: ;
            endcase
        end
        v = {(m_ph == P_PRST) || (m_ph == P_FAULT), m_ph == P_RUN, m_ph == P_RUN,
             m_ph == P_FAULT, 2'(m_retry)};
        if (v !== m_prev) begin
            e.stamp = stamp;
            e.vec   = v;
            exp_q.push_back(e);
        end
        m_prev = v;
    endtask

    // One clock of stimulus: drive, predict the next edge, wait past it.
    task automatic cycle(input logic r, input logic lk, input logic fr);
        rst           = r;
        pll_locked    = lk;
        force_restart = fr;
        model_step(cyc + 1, r, lk, fr);
        @(negedge sys_clk);
    endtask

    task automatic run_n(input int n, input logic lk);
        for (int i = 0; i < n; i++) cycle(1'b0, lk, 1'b0);
    endtask

    task automatic run_until(input int ph, input int el, input logic lk, input int budget, input string what);
        int n;
        n = 0;
        while (!(m_ph == ph && (el < 0 || m_el == el)) && n < budget) begin
            cycle(1'b0, lk, 1'b0);
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL wait_%s: phase %0d after %0d cycles, required phase %0d", what, m_ph, n, ph);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [5:0] prev;
        ev_t        e;
        prev = 6'bxxxxxx;
        forever begin
            @(posedge sys_clk);
            #1;
            if (dut_vec !== prev) begin
                prev = dut_vec;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got vec=%b at cycle %0d, required no change", dut_vec, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.vec !== dut_vec || e.stamp != cyc) begin
                        n_bad++;
                        $display("FAIL output_event: got vec=%b at cycle %0d, required vec=%b at cycle %0d",
                                 dut_vec, cyc, e.vec, e.stamp);
                    end else begin
                        $display("ok  cycle %0d vec=%b", cyc, dut_vec);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic lk;
        int   run_len;

        rst = 1'b1; pll_locked = 1'b0; force_restart = 1'b0;

        // Reset, then lock arrives at cycle 10 and a clean RUN follows.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        while (cyc < 9) cycle(1'b0, 1'b0, 1'b0);
        run_until(P_RUN, -1, 1'b1, 200, "first_run");
        run_n(10, 1'b1);

        // Lock lost in RUN for a random time, then recovers.
        run_n(1 + $urandom_range(0, 5), 1'b0);
        run_until(P_RUN, -1, 1'b1, 200, "relock");
        run_n(5, 1'b1);

        // One-cycle glitch while STABLE is counting.
        run_n(1, 1'b0);
        run_until(P_STAB, 3, 1'b1, 200, "stable3");
        run_n(1, 1'b0);
        run_until(P_RUN, -1, 1'b1, 200, "glitch_run");
        run_n(5, 1'b1);

        // force_restart lands on the same edge the lock loss reaches the FSM.
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        run_until(P_RUN, -1, 1'b1, 200, "force_run");
        run_n(5, 1'b1);

        // No lock at all: timeouts until FAULT, then 100 cycles with noise.
        run_until(P_FAULT, -1, 1'b0, 400, "fault");
        for (int i = 0; i < 100; i++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));

        // Reset out of FAULT and a normal lock sequence.
        cycle(1'b1, 1'b1, 1'b0);
        run_until(P_RUN, -1, 1'b1, 200, "after_fault");
        run_n(5, 1'b1);

        // Randomised lock runs, restart pulses and occasional resets.
        lk = 1'b1;
        run_len = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_len == 0) begin
                lk = ~lk;
                run_len = lk ? $urandom_range(1, 60) : $urandom_range(1, 45);
            end
            run_len--;
            cycle(1'($urandom_range(0, 999) < 4), lk, 1'($urandom_range(0, 99) < 2));
        end
        run_n(3, 1'b1);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: got %0d expected changes never seen, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
